// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for a six-position, seven-segment display.
//
// A free-running prescaler makes a scan tick every 2^SCAN_EXP clocks. Each
// tick moves the active position down by one (5,4,3,2,1,0,5,...).
//
// The displayed digits, decimal points and blank bits are copied into
// snapshot registers only when the scan wraps from position 0 back to 5.
// A frame therefore never shows a mix of old and new data.
//
// Segment and dp decode is combinational from the registered position and the
// snapshot, so the outputs never lag seg7_sel. lamp_test overrides the decode
// but does not touch the scan or the snapshot.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   digits_in   six BCD digits, digit i in [4i+3:4i], digit 0 leftmost
//   dp_mask     bit i lights the decimal point of digit i
//   blank_mask  bit i blanks digit i (segments and dp)
//   lamp_test   forces every segment and the dp on
//   seg7_sel    active digit position, 0..5
//   seg7_out    segments abcdefg, MSB = a, active-high
//   dpt_out     decimal point of the active digit, active-high
//   frame_done  one-cycle pulse in the cycle after a frame wrap
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int SCAN_EXP = 13
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] digits_in,
   input  logic [5:0]  dp_mask,
   input  logic [5:0]  blank_mask,
   input  logic        lamp_test,
   output logic [2:0]  seg7_sel,
   output logic [6:0]  seg7_out,
   output logic        dpt_out,
   output logic        frame_done
);

   localparam logic [2:0] SEL_FIRST = 3'd5;
   localparam logic [2:0] SEL_LAST  = 3'd0;

   logic [SCAN_EXP-1:0] prescaler;
   logic                scan_tick;
   logic                frame_wrap;

   logic [23:0]         snap_digits;
   logic [5:0]          snap_dp;
   logic [5:0]          snap_blank;

   logic [3:0]          cur_digit;
   logic                cur_dp;
   logic                cur_blank;
   logic [6:0]          digit_code;

   assign scan_tick  = &prescaler;
   assign frame_wrap = scan_tick && (seg7_sel == SEL_LAST);

   // Prescaler. It wraps naturally from all ones back to zero.
   // NOTE: clocked state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   // Scan position, frame pulse and snapshot.
   // The snapshot is loaded on the same edge that moves the scan from 0 to 5.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seg7_sel    <= SEL_FIRST;
         frame_done  <= 1'b0;
         snap_digits <= '0;
         snap_dp     <= '0;
         snap_blank  <= '0;
      end else begin
         frame_done <= frame_wrap;
         if (frame_wrap) begin
            seg7_sel    <= SEL_FIRST;
            snap_digits <= digits_in;
            snap_dp     <= dp_mask;
            snap_blank  <= blank_mask;
         end else if (scan_tick) begin
            seg7_sel <= seg7_sel - 3'd1;
         end
      end
   end

   // Select the active digit from the snapshot.
   // Positions 6 and 7 cannot occur; they fall back to position 0 so that the
   // mux stays fully specified.
   // NOTE: every always_comb output gets a default first, so no path can leave
   // a signal unassigned and infer a latch.
   always_comb begin
      cur_digit = snap_digits[3:0];
      cur_dp    = snap_dp[0];
      cur_blank = snap_blank[0];
      case (seg7_sel)
         3'd1: begin
            cur_digit = snap_digits[7:4];
            cur_dp    = snap_dp[1];
            cur_blank = snap_blank[1];
         end
         3'd2: begin
            cur_digit = snap_digits[11:8];
            cur_dp    = snap_dp[2];
            cur_blank = snap_blank[2];
         end
         3'd3: begin
            cur_digit = snap_digits[15:12];
            cur_dp    = snap_dp[3];
            cur_blank = snap_blank[3];
         end
         3'd4: begin
            cur_digit = snap_digits[19:16];
            cur_dp    = snap_dp[4];
            cur_blank = snap_blank[4];
         end
         3'd5: begin
            cur_digit = snap_digits[23:20];
            cur_dp    = snap_dp[5];
            cur_blank = snap_blank[5];
         end
         default: ;
      endcase
   end

   // BCD to abcdefg. Values 10..15 are not digits and show a dash.
   always_comb begin
      digit_code = 7'b0000001;
      case (cur_digit)
         4'd0: digit_code = 7'b1111110;
         4'd1: digit_code = 7'b0110000;
         4'd2: digit_code = 7'b1101101;
         4'd3: digit_code = 7'b1111001;
         4'd4: digit_code = 7'b0110011;
         4'd5: digit_code = 7'b1011011;
         4'd6: digit_code = 7'b1011111;
         4'd7: digit_code = 7'b1110000;
         4'd8: digit_code = 7'b1111111;
         4'd9: digit_code = 7'b1111011;
         default: ;
      endcase
   end

   // Output priority: lamp test, then blanking, then the normal decode.
   always_comb begin
      seg7_out = digit_code;
      dpt_out  = cur_dp;
      if (lamp_test) begin
         seg7_out = 7'b1111111;
         dpt_out  = 1'b1;
      end else if (cur_blank) begin
         seg7_out = 7'b0000000;
         dpt_out  = 1'b0;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver, built with SCAN_EXP = 2 (4 clocks per
// tick, 24 clocks per frame).
//
// Before each clock edge, the bench works out the outputs expected after that
// edge and pushes them onto a queue. The model uses the number of edges since
// reset release and its own snapshot of the inputs. After the edge, the entry
// is popped and compared against the DUT.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

   localparam int SCAN_EXP = 2;
   localparam int TICK     = 1 << SCAN_EXP;
   localparam int FRAME    = 6 * TICK;

   logic        clk;
   logic        reset;
   logic [23:0] digits_in;
   logic [5:0]  dp_mask;
   logic [5:0]  blank_mask;
   logic        lamp_test;
   logic [2:0]  seg7_sel;
   logic [6:0]  seg7_out;
   logic        dpt_out;
   logic        frame_done;

   typedef struct packed {
      logic [2:0] sel;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } exp_t;

   exp_t        sb_q[$];
   int          checks;
   int          errors;
   int          cyc;
   logic [23:0] m_digits;
   logic [5:0]  m_dp;
   logic [5:0]  m_blank;

   seg7_scan_driver #(.SCAN_EXP(SCAN_EXP)) dut (
      .clk        (clk),
      .reset      (reset),
      .digits_in  (digits_in),
      .dp_mask    (dp_mask),
      .blank_mask (blank_mask),
      .lamp_test  (lamp_test),
      .seg7_sel   (seg7_sel),
      .seg7_out   (seg7_out),
      .dpt_out    (dpt_out),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] bcd_code(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1111110;
         4'd1: return 7'b0110000;
         4'd2: return 7'b1101101;
         4'd3: return 7'b1111001;
         4'd4: return 7'b0110011;
         4'd5: return 7'b1011011;
         4'd6: return 7'b1011111;
         4'd7: return 7'b1110000;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1111011;
         default: return 7'b0000001;
      endcase
   endfunction

   // Expected outputs after edge n (n edges since reset release).
   function automatic exp_t model(input int n);
      exp_t e;
      int   pos;
      pos   = 5 - ((n / TICK) % 6);
      e.sel = 3'(pos);
      e.fd  = (n > 0) && (n % FRAME == 0);
      if (lamp_test) begin
         e.seg = 7'b1111111;
         e.dp  = 1'b1;
      end else if (m_blank[pos]) begin
         e.seg = 7'b0000000;
         e.dp  = 1'b0;
      end else begin
         e.seg = bcd_code(m_digits[4*pos +: 4]);
         e.dp  = m_dp[pos];
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic compare(input exp_t e);
      check("seg7_sel",   {5'd0, seg7_sel}, {5'd0, e.sel});
      check("seg7_out",   {1'b0, seg7_out}, {1'b0, e.seg});
      check("dpt_out",    {7'd0, dpt_out},  {7'd0, e.dp});
      check("frame_done", {7'd0, frame_done}, {7'd0, e.fd});
   endtask

   // One clock. If the coming edge is a frame wrap, the model snapshots the
   // inputs first.
   task automatic step();
      exp_t e;
      if ((cyc + 1) % FRAME == 0) begin
         m_digits = digits_in;
         m_dp     = dp_mask;
         m_blank  = blank_mask;
      end
      sb_q.push_back(model(cyc + 1));
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty cyc=%0d observed=0 expected=1", cyc);
      end else begin
         e = sb_q.pop_front();
         compare(e);
      end
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic model_reset();
      cyc      = 0;
      m_digits = '0;
      m_dp     = '0;
      m_blank  = '0;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b0;
      digits_in  = 24'h876543;
      dp_mask    = '0;
      blank_mask = '0;
      lamp_test  = 1'b0;
      model_reset();

      // Reset state: position 5, showing "0" with dp off, no frame pulse.
      repeat (2) @(posedge clk);
      #1;
      compare('{sel: 3'd5, seg: 7'b1111110, dp: 1'b0, fd: 1'b0});

      // Release away from the edge, then run two frames. The first frame shows
      // the reset snapshot (all zeros); the second frame shows 876543.
      @(negedge clk);
      reset = 1'b1;
      run_to(2 * FRAME);

      // Change the inputs mid-frame. Digits 111111 are captured at edge 72.
      // The switch to 999999 happens while position 3 is active (edges 80..83),
      // so it must not appear until the frame that starts at edge 96.
      digits_in = 24'h111111;
      run_to(3 * FRAME + 9);
      digits_in = 24'h999999;
      run_to(5 * FRAME);

      // Digit 0 is 0xC with every dp lit. The first frame has digit 0 blanked;
      // the following frame shows it unblanked as a dash with dp on.
      digits_in  = 24'h00000C;
      dp_mask    = 6'b111111;
      blank_mask = 6'b000001;
      run_to(6 * FRAME);
      blank_mask = 6'b000000;
      run_to(8 * FRAME);

      // Lamp test for three clocks mid-digit. The scan must carry on as before.
      blank_mask = 6'b111111;
      run_to(8 * FRAME + 5);
      lamp_test = 1'b1;
      run_to(8 * FRAME + 8);
      lamp_test = 1'b0;
      run_to(8 * FRAME + 13);

      // Asynchronous reset while position 2 is active (edges 204..207).
      // Assert it between edges and check before any further edge.
      #2;
      check("pre_reset_sel", {5'd0, seg7_sel}, 8'd2);
      reset = 1'b0;
      #1;
      check("async_sel", {5'd0, seg7_sel}, 8'd5);
      check("async_seg", {1'b0, seg7_out}, 8'h7E);
      check("async_dp",  {7'd0, dpt_out}, 8'd0);
      check("async_fd",  {7'd0, frame_done}, 8'd0);

      // Restart from a clean reset and run one frame plus a little.
      @(negedge clk);
      model_reset();
      reset = 1'b1;
      run_to(FRAME + 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter SCAN_EXP, default 13, giving the scan tick period in clk cycles as 2^SCAN_EXP.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port digits_in, input, 24 bits: six BCD digits, digit i in bits [4i+3:4i], digit 0 the leftmost position.
REQ-005 The block SHALL have port dp_mask, input, 6 bits: bit i = 1 lights the decimal point of digit i.
REQ-006 The block SHALL have port blank_mask, input, 6 bits: bit i = 1 blanks digit i, both segments and dp.
REQ-007 The block SHALL have port lamp_test, input, 1 bit: forces all segments and dp on.
REQ-008 The block SHALL have port seg7_sel, output, 3 bits: the active digit position, 0..5.
REQ-009 The block SHALL have port seg7_out, output, 7 bits: segments abcdefg, MSB = a, active-high.
REQ-010 The block SHALL have port dpt_out, output, 1 bit: decimal point of the active digit, active-high.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame wrap.

Function
REQ-012 Prescaler: the block SHALL use a SCAN_EXP-bit free-running up-counter that wraps to 0, and SHALL assert scan tick in the cycle the counter is all ones.
REQ-013 Scan order: on each tick, seg7_sel SHALL step 5,4,3,2,1,0,5,... (descending with wrap); without a tick it SHALL hold.
REQ-014 Frame wrap: a tick with seg7_sel = 0 SHALL, on the same edge, set seg7_sel to 5, load the snapshot registers, and drive frame_done = 1 for exactly that following cycle.
REQ-015 Snapshot: the snapshot registers SHALL capture digits_in, dp_mask and blank_mask only at frame wrap, so that input changes mid-frame never alter the digits shown in the current frame.
REQ-016 Decode: seg7_out SHALL be combinational from the registered seg7_sel and the snapshot, so it always corresponds to the current seg7_sel with zero cycles of skew.
REQ-017 Digit codes SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-018 A BCD value 10..15 SHALL display a dash, seg7_out = 0000001.
REQ-019 A blanked digit SHALL drive seg7_out = 0000000 and dpt_out = 0, regardless of its value and of dp_mask.
REQ-020 The non-blanked dpt_out SHALL equal the snapshot dp bit of the active digit.
REQ-021 lamp_test = 1 SHALL force seg7_out = 1111111 and dpt_out = 1 combinationally, override blanking, and leave the scan and snapshot unaffected.
REQ-022 frame_done SHALL be 0 in every cycle other than the one specified in REQ-014.

Reset
REQ-023 While reset = 0, the block SHALL hold the prescaler at 0, seg7_sel at 5, frame_done at 0, and the snapshot digits, dp and blank bits all at 0; the display therefore shows "0" with dp off.
REQ-024 Reset asserted mid-frame SHALL take effect immediately, with no clock required.
REQ-025 After reset releases, the first tick SHALL occur 2^SCAN_EXP edges later, and the first snapshot load SHALL occur at the first frame wrap, 6 ticks after release.

Verification (SCAN_EXP=2)
REQ-026 Release reset with digits_in=24'h876543 and masks 0 -> seg7_sel=5 for 4 clocks, then 4,3,2,1,0; display shows 0000000-free "0" digits until the wrap, then sel 5 shows 8 (1111111) and sel 0 shows 3 (1111001).
REQ-027 Count one full frame -> frame_done is high exactly one cycle per 24 clocks, in the cycle after seg7_sel goes from 0 to 5.
REQ-028 Change digits_in from 24'h111111 to 24'h999999 while seg7_sel=3 -> the remaining digits of that frame show 1 (0110000); the next frame shows 9 (1111011).
REQ-029 Set blank_mask=6'b000001 with dp_mask=6'b111111, and digit 0 = 4'hC at sel 0 -> blanked (0000000, dp 0); with blank_mask=0 -> dash 0000001 with dp 1.
REQ-030 Pulse lamp_test for 3 clocks mid-digit -> seg7_out=1111111 and dpt_out=1 in those cycles; the seg7_sel sequence is unchanged.
REQ-031 Assert reset while seg7_sel=2 -> seg7_sel=5, seg7_out=1111110, frame_done=0 immediately, with no clock edge.
